// File: rtl/ram_responder_if.sv
// Shared bus types and the initiator/responder bus between the memory
// controller and the RAM model.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface ram_responder_if;
  import cpu_types_pkg::*;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM model with a programmable BUSY wait-state sequence,
// answering single-word reads and writes from the memory controller.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT       = 2,
  parameter int unsigned ADDR_BITS = 10
) (
  input logic            CLK,
  input logic            RST,
  ram_responder_if.slave ram
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [0:DEPTH-1];

  ramstate_t   state, nxt_state;
  logic [3:0]  cnt, nxt_cnt;
  logic [31:0] cap_addr, nxt_addr;
  logic        cap_ren, nxt_ren;
  logic        cap_wen, nxt_wen;
  logic [31:0] load, nxt_load;

  logic req, invalid, key_changed, eval;

  assign req         = ram.ramREN | ram.ramWEN;
  assign invalid     = (ram.ramREN & ram.ramWEN) || (ram.ramaddr[1:0] != 2'b00) ||
                       ((ram.ramaddr >> (ADDR_BITS + 2)) != '0);
  assign key_changed = {ram.ramaddr, ram.ramREN, ram.ramWEN} != {cap_addr, cap_ren, cap_wen};

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_addr  = cap_addr;
    nxt_ren   = cap_ren;
    nxt_wen   = cap_wen;
    eval      = 1'b0;
    nxt_load  = '0;

    unique case (state)
      FREE:   eval = 1'b1;
      BUSY: begin
        if (!req)             nxt_state = FREE;
        else if (key_changed) eval = 1'b1;
        else if (cnt == '0)   nxt_state = ACCESS;
        else                  nxt_cnt = cnt - 4'd1;
      end
      ACCESS: nxt_state = FREE;
      ERROR:  if (!req || key_changed) nxt_state = FREE;
      default: nxt_state = FREE;
    endcase

    // A key change in BUSY takes the same path as a fresh request from FREE,
    // so the latency restarts from the top.
    if (eval) begin
      if (!req) begin
        nxt_state = FREE;
      end else begin
        nxt_addr = ram.ramaddr;
        nxt_ren  = ram.ramREN;
        nxt_wen  = ram.ramWEN;
        if (invalid) begin
          nxt_state = ERROR;
        end else if (LAT != 0) begin
          nxt_state = BUSY;
          nxt_cnt   = 4'(LAT - 1);
        end else begin
          nxt_state = ACCESS;
        end
      end
    end

    if (nxt_state == ERROR)
      nxt_load = 32'hBAD1_BAD1;
    else if (nxt_state == ACCESS && nxt_ren)
      nxt_load = mem[nxt_addr[ADDR_BITS+1:2]];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= FREE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_ren  <= 1'b0;
      cap_wen  <= 1'b0;
      load     <= '0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      cap_addr <= nxt_addr;
      cap_ren  <= nxt_ren;
      cap_wen  <= nxt_wen;
      load     <= nxt_load;
    end
  end

  // Reset forces state out of ACCESS asynchronously, which is what
  // discards a write caught by reset before its commit edge.
  always_ff @(posedge CLK) begin
    if (state == ACCESS && cap_wen)
      mem[cap_addr[ADDR_BITS+1:2]] <= ram.ramstore;
  end

  assign ram.ramstate = state;
  assign ram.ramload  = load;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one instance with LAT=2, one with LAT=0.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int unsigned nvec = 0;
  int unsigned nmis = 0;

  ram_responder_if rif2 ();
  ram_responder_if rif0 ();

  ram_responder #(.LAT(2), .ADDR_BITS(10)) u_dut2 (.CLK(CLK), .RST(RST), .ram(rif2));
  ram_responder #(.LAT(0), .ADDR_BITS(10)) u_dut0 (.CLK(CLK), .RST(RST), .ram(rif0));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set2(input logic ren, input logic wen, input logic [31:0] addr,
                      input logic [31:0] store);
    rif2.ramREN   = ren;
    rif2.ramWEN   = wen;
    rif2.ramaddr  = addr;
    rif2.ramstore = store;
  endtask

  task automatic drop2();
    rif2.ramREN = 1'b0;
    rif2.ramWEN = 1'b0;
  endtask

  task automatic expect2(input string tag, input ramstate_t st, input logic [31:0] ld);
    check({tag, ".state"}, 32'(rif2.ramstate), 32'(st));
    check({tag, ".load"}, rif2.ramload, ld);
  endtask

  // Full LAT=2 transaction: BUSY, BUSY, ACCESS, FREE.
  task automatic xact2(input string tag, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] store,
                       input logic [31:0] exp_load);
    set2(ren, wen, addr, store);
    tick(); expect2({tag, ".b1"}, BUSY, 32'h0);
    tick(); expect2({tag, ".b2"}, BUSY, 32'h0);
    tick(); expect2({tag, ".acc"}, ACCESS, exp_load);
    drop2();
    tick(); expect2({tag, ".free"}, FREE, 32'h0);
  endtask

  task automatic invalid2(input string tag, input logic ren, input logic wen,
                          input logic [31:0] addr);
    set2(ren, wen, addr, 32'hFFFF_FFFF);
    tick(); expect2({tag, ".err"}, ERROR, 32'hBAD1_BAD1);
    tick(); expect2({tag, ".hold"}, ERROR, 32'hBAD1_BAD1);
    drop2();
    tick(); expect2({tag, ".free"}, FREE, 32'h0);
  endtask

  initial begin
    set2(1'b0, 1'b0, 32'h0, 32'h0);
    rif0.ramREN = 1'b0; rif0.ramWEN = 1'b0; rif0.ramaddr = '0; rif0.ramstore = '0;
    #1;
    expect2("rst", FREE, 32'h0);
    #11 RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick(); expect2("idle", FREE, 32'h0);
    end

    xact2("wr40", 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0);
    xact2("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);

    // Reset mid-BUSY on a write: immediate FREE, write discarded.
    set2(1'b0, 1'b1, 32'h40, 32'h1111_1111);
    tick(); expect2("rb.b1", BUSY, 32'h0);
    #1 RST = 1'b1;
    #1 expect2("rb.async", FREE, 32'h0);
    drop2();
    #1 RST = 1'b0;
    tick(); expect2("rb.idle", FREE, 32'h0);

    // Reset during ACCESS of a write: write discarded.
    set2(1'b0, 1'b1, 32'h40, 32'h2222_2222);
    tick(); tick(); tick(); expect2("ra.acc", ACCESS, 32'h0);
    #1 RST = 1'b1;
    #1 expect2("ra.async", FREE, 32'h0);
    drop2();
    #1 RST = 1'b0;
    tick();
    xact2("rd40b", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);

    // Address change after one BUSY restarts latency.
    xact2("wr44", 1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 32'h0);
    set2(1'b1, 1'b0, 32'h40, 32'h0);
    tick(); expect2("ac.b0", BUSY, 32'h0);
    rif2.ramaddr = 32'h44;
    tick(); expect2("ac.b1", BUSY, 32'h0);
    tick(); expect2("ac.b2", BUSY, 32'h0);
    tick(); expect2("ac.acc", ACCESS, 32'hCAFE_F00D);
    drop2();
    tick(); expect2("ac.free", FREE, 32'h0);

    xact2("wr0", 1'b0, 1'b1, 32'h0, 32'h0BAD_CAFE, 32'h0);
    invalid2("inv.rw", 1'b1, 1'b1, 32'h40);
    invalid2("inv.mis", 1'b0, 1'b1, 32'h41);
    invalid2("inv.rng", 1'b0, 1'b1, 32'h1000);
    xact2("rd40c", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    xact2("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0BAD_CAFE);

    // Back-to-back writes with a one-cycle FREE bubble.
    set2(1'b0, 1'b1, 32'h8, 32'h8888_8888);
    tick(); expect2("bb.a.b1", BUSY, 32'h0);
    tick(); expect2("bb.a.b2", BUSY, 32'h0);
    tick(); expect2("bb.a.acc", ACCESS, 32'h0);
    tick(); expect2("bb.bubble", FREE, 32'h0);
    set2(1'b0, 1'b1, 32'hC, 32'hCCCC_CCCC);
    tick(); expect2("bb.b.b1", BUSY, 32'h0);
    tick(); expect2("bb.b.b2", BUSY, 32'h0);
    tick(); expect2("bb.b.acc", ACCESS, 32'h0);
    drop2();
    tick(); expect2("bb.b.free", FREE, 32'h0);
    xact2("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 32'h8888_8888);
    xact2("rdC", 1'b1, 1'b0, 32'hC, 32'h0, 32'hCCCC_CCCC);

    // LAT=0 instance: ACCESS in the cycle right after the request.
    rif0.ramWEN = 1'b1; rif0.ramaddr = 32'h0; rif0.ramstore = 32'h1234_5678;
    tick();
    check("l0.wr.state", 32'(rif0.ramstate), 32'(ACCESS));
    rif0.ramWEN = 1'b0;
    tick();
    check("l0.wr.free", 32'(rif0.ramstate), 32'(FREE));
    rif0.ramREN = 1'b1; rif0.ramstore = 32'h0;
    tick();
    check("l0.rd.state", 32'(rif0.ramstate), 32'(ACCESS));
    check("l0.rd.load", rif0.ramload, 32'h1234_5678);
    rif0.ramREN = 1'b0;
    tick();
    check("l0.rd.free", 32'(rif0.ramstate), 32'(FREE));
    check("l0.rd.load0", rif0.ramload, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Word-addressed RAM model that sits on the RAM side of the memory controller. It accepts single-word read and write requests on the ramREN/ramWEN/ramaddr/ramstore bus and advances a programmable wait-state sequence reported on ramstate (FREE/BUSY/ACCESS/ERROR). It returns read data on ramload. It is the responder end of the bus the memory controller drives, used in simulation and synthesis in place of the board RAM.

## Interface
- LAT, 2: number of BUSY cycles before ACCESS; legal range 0..15.
- ADDR_BITS, 10: word-address width; depth is 2^ADDR_BITS words of 32 bits.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- ramREN  in  1  read request, held by the initiator until ACCESS.
- ramWEN  in  1  write request, held by the initiator until ACCESS.
- ramaddr  in  32  byte address of the request.
- ramstore  in  32  write data.
- ramload  out  32  read data; valid only while ramstate == ACCESS.
- ramstate  out  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.

## Operation
- A request is present when ramREN or ramWEN is 1. The request key is {ramaddr, ramREN, ramWEN}.
- Invalid request: ramREN & ramWEN, or ramaddr[1:0] != 0, or ramaddr[31:ADDR_BITS+2] != 0.
- State register drives ramstate directly. Transitions:
  - FREE: no request -> FREE. Invalid request -> ERROR. Valid request -> capture key, then BUSY with counter = LAT-1 if LAT > 0, else ACCESS.
  - BUSY: request dropped -> FREE. Key differs from the captured key -> re-evaluate exactly as from FREE; this restarts the latency. Otherwise, counter == 0 -> ACCESS; else decrement.
  - ACCESS: -> FREE unconditionally. This gives one FREE bubble between back-to-back requests.
  - ERROR: request dropped or key changed -> FREE. Otherwise stay in ERROR.
- Read: on the edge entering ACCESS, ramload <= mem[captured word index] if the captured op is a read. Word index = addr[ADDR_BITS+1:2].
- Write: on the edge leaving ACCESS, mem[index] <= ramstore sampled at that edge. ramstore changes during BUSY do not restart the latency.
- ramload = 0 in FREE and BUSY, and in ACCESS for writes. ramload = 32'hBAD1BAD1 in ERROR.
- Memory array is not reset; contents are undefined until written. RST never alters the array.

## Timing
- Reset values: ramstate = FREE, ramload = 0, counter = 0, captured key = 0.
- Request first present in cycle n (ramstate FREE):
  - BUSY in cycles n+1..n+LAT.
  - ACCESS in cycle n+LAT+1.
  - FREE in cycle n+LAT+2.
- Latency from request to ACCESS is LAT+1 cycles. Throughput is one word per LAT+2 cycles.
- ACCESS lasts exactly one cycle. The initiator must hold the key stable through ACCESS.
- Reset asserted mid-request: outputs return to reset values immediately (asynchronous). A write in BUSY is discarded. A write in ACCESS with reset asserted before the edge is discarded.
- A key change in the same cycle the counter reaches 0 restarts the latency; no ACCESS occurs for the old key.
- A request dropped during ACCESS still completes: the write is committed at the edge leaving ACCESS.

## Test plan
- Reset then idle, LAT=2: ramstate = FREE, ramload = 0 for 10 cycles. Assert RST mid-BUSY -> FREE within the same cycle.
- Write 0xDEADBEEF to 0x40, then read 0x40, LAT=2:
  - Each request shows BUSY, BUSY, ACCESS, then FREE.
  - The read shows ramload = 0xDEADBEEF only in its ACCESS cycle.
- LAT=0: read 0x0 after writing 0x12345678 -> ACCESS in the cycle after request assertion, ramload = 0x12345678.
- Address change during BUSY (0x40 -> 0x44 after 1 BUSY cycle, LAT=2) -> two further BUSY cycles, then ACCESS returns mem[0x44].
- Invalid requests:
  - ramREN = ramWEN = 1 -> ERROR, ramload = 0xBAD1BAD1, held until ramREN drops -> FREE.
  - Misaligned 0x41 -> ERROR.
  - Address 0x1000 with ADDR_BITS=10 -> ERROR.
  - Memory is unchanged after each.
- Back-to-back writes to 0x8 and 0xC with the initiator moving to the next key right after ACCESS -> FREE bubble between the two sequences, and both words read back correctly.
